// File: rtl/csr_unit_mtrap.sv
// Machine-mode CSR file: ID/status/trap CSRs, free-running counters,
// trap entry / MRET sequencing and interrupt-pending generation.
module csr_unit_mtrap #(
    parameter logic [31:0] VEND_ID     = 32'h0,
    parameter logic [31:0] ARCH_ID     = 32'h0,
    parameter logic [31:0] IMPL_ID     = 32'h0,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter int unsigned COUNTER_W   = 64,
    parameter logic [25:0] MISA_EXT    = 26'h100,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  op_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    output logic        illegal_o,
    input  logic        instret_i,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_sw_i,
    output logic [31:0] trap_vec_o,
    output logic [31:0] epc_o,
    output logic        irq_pending_o
);
    localparam int unsigned XLEN = 32;

    logic                 mie_bit, mpie_bit;
    logic [2:0]           mie_en, mip_q;   // {external, timer, software}
    logic [XLEN-1:0]      mtvec, mscratch, mcause;
    logic [XLEN-3:0]      mepc_hi;
    logic [COUNTER_W-1:0] mcycle, minstret;
    logic [63:0]          cyc64, ins64;
    logic [XLEN-1:0]      mstatus_rd, mie_rd, mip_rd, rv, wv, base;
    logic                 hit, wr_en;
    logic                 unused_pc_lsb;

    assign unused_pc_lsb = &{1'b0, trap_pc_i[1:0]};

    assign cyc64      = 64'(mcycle);
    assign ins64      = 64'(minstret);
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_bit, 3'b0, mie_bit, 3'b0};
    assign mie_rd     = {20'b0, mie_en[2], 3'b0, mie_en[1], 3'b0, mie_en[0], 3'b0};
    assign mip_rd     = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
    assign epc_o      = {mepc_hi, 2'b00};

    // Read mux; an unmatched address is unimplemented and reads 0
    always_comb begin
        rv  = '0;
        hit = 1'b1;
        case (addr_i)
            12'hC00, 12'hB00: rv = cyc64[31:0];
            12'hC80, 12'hB80: rv = cyc64[63:32];
            12'hC02, 12'hB02: rv = ins64[31:0];
            12'hC82, 12'hB82: rv = ins64[63:32];
            12'hF11: rv = VEND_ID;
            12'hF12: rv = ARCH_ID;
            12'hF13: rv = IMPL_ID;
            12'hF14: rv = HART_ID;
            12'h300: rv = mstatus_rd;
            12'h301: rv = {2'b01, 4'b0, MISA_EXT};
            12'h304: rv = mie_rd;
            12'h305: rv = mtvec;
            12'h340: rv = mscratch;
            12'h341: rv = epc_o;
            12'h342: rv = mcause;
            12'h344: rv = mip_rd;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        case (op_i)
            2'b00:   wv = data_i;
            2'b01:   wv = rv | data_i;
            2'b10:   wv = rv & ~data_i;
            default: wv = rv;
        endcase
    end

    assign data_o    = rv;
    assign illegal_o = !hit || (we_i && (addr_i[11:10] == 2'b11));
    // Trap and MRET both pre-empt a CSR write in the same cycle
    assign wr_en     = we_i && (op_i != 2'b11) && !illegal_o && !trap_i && !mret_i;

    assign base = {mtvec[31:2], 2'b00};
    always_comb begin
        if (mtvec[1:0] == 2'b01 && trap_cause_i[31])
            trap_vec_o = base + {25'b0, trap_cause_i[4:0], 2'b00};
        else
            trap_vec_o = base;
    end

    assign irq_pending_o = mie_bit && |(mip_q & mie_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mie_bit  <= 1'b0;
            mpie_bit <= 1'b0;
            mie_en   <= '0;
            mip_q    <= '0;
            mtvec    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch <= '0;
            mepc_hi  <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mip_q <= {irq_ext_i, irq_timer_i, irq_sw_i};

            if (trap_i) begin
                mepc_hi  <= trap_pc_i[31:2];
                mcause   <= trap_cause_i;
                mpie_bit <= mie_bit;
                mie_bit  <= 1'b0;
            end else if (mret_i) begin
                mie_bit  <= mpie_bit;
                mpie_bit <= 1'b1;
            end else if (wr_en) begin
                case (addr_i)
                    12'h300: begin
                        mie_bit  <= wv[3];
                        mpie_bit <= wv[7];
                    end
                    12'h304: mie_en   <= {wv[11], wv[7], wv[3]};
                    12'h305: mtvec    <= {wv[31:2], wv[1] ? mtvec[1:0] : wv[1:0]};
                    12'h340: mscratch <= wv;
                    12'h341: mepc_hi  <= wv[31:2];
                    12'h342: mcause   <= wv;
                    default: ;
                endcase
            end

            // Counter writes replace one half and suppress that cycle's increment
            if (wr_en && addr_i == 12'hB00)
                mcycle <= COUNTER_W'({cyc64[63:32], wv});
            else if (wr_en && addr_i == 12'hB80)
                mcycle <= COUNTER_W'({wv, cyc64[31:0]});
            else
                mcycle <= mcycle + COUNTER_W'(1);

            if (wr_en && addr_i == 12'hB02)
                minstret <= COUNTER_W'({ins64[63:32], wv});
            else if (wr_en && addr_i == 12'hB82)
                minstret <= COUNTER_W'({wv, ins64[31:0]});
            else if (instret_i)
                minstret <= minstret + COUNTER_W'(1);
        end
    end
endmodule
